register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_write_decoder.sv | 20 ++
 rtl/register_file.sv | 81 ++++++++
 tb/tb_register_file.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants and helpers for the integer register file.
package register_file_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned REG_AW   = $clog2(NREG);
  localparam int unsigned REG_ZERO = 0;

  // True when an index names the hard-wired zero register
  function automatic logic is_reg_zero(input logic [REG_AW-1:0] addr);
    return addr == REG_AW'(REG_ZERO);
  endfunction

endpackage

// File: rtl/register_file_write_decoder.sv
// One-hot write-select demultiplexer: sel[i] = en && (addr == i).
module write_decoder
  import register_file_pkg::*;
#(
  parameter int unsigned NREG_P = register_file_pkg::NREG,
  parameter int unsigned AW_P   = register_file_pkg::REG_AW
) (
  input  logic [AW_P-1:0]   addr,
  input  logic              en,
  output logic [NREG_P-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREG_P; i++) begin
      sel[i] = en && (addr == AW_P'(i));
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with x0 hard-wired to zero.
// Optional same-cycle write-to-read forwarding: define REGFILE_WRITE_BYPASS_EN.
module register_file #(
  parameter int unsigned XLEN = register_file_pkg::XLEN,
  parameter int unsigned NREG = register_file_pkg::NREG
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [register_file_pkg::REG_AW-1:0] rs1_addr_i,
  input  logic [register_file_pkg::REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]                     rs1_data_o,
  output logic [XLEN-1:0]                     rs2_data_o,
  input  logic [register_file_pkg::REG_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]                     rd_data_i,
  input  logic                                rd_we_i
);

  import register_file_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] wr_sel;
  logic [XLEN-1:0] rs1_store;
  logic [XLEN-1:0] rs2_store;

  write_decoder #(
    .NREG_P (NREG),
    .AW_P   (REG_AW)
  ) u_write_decoder (
    .addr (rd_addr_i),
    .en   (rd_we_i),
    .sel  (wr_sel)
  );

  // Entry 0 never takes a write, so a decoded select for x0 is simply dropped
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wr_sel[i]) begin
        regs_d[i] = rd_data_i;
      end
    end
    regs_d[0] = '0;
  end

  // Reset has priority over a coincident write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rs1_store = is_reg_zero(rs1_addr_i) ? '0 : regs_q[rs1_addr_i];
    rs2_store = is_reg_zero(rs2_addr_i) ? '0 : regs_q[rs2_addr_i];
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = rd_we_i && !rst_i && !is_reg_zero(rd_addr_i);

  always_comb begin
    rs1_data_o = (fwd_ok && (rd_addr_i == rs1_addr_i)) ? rd_data_i : rs1_store;
    rs2_data_o = (fwd_ok && (rd_addr_i == rs2_addr_i)) ? rd_data_i : rs2_store;
  end
`else
  always_comb begin
    rs1_data_o = rs1_store;
    rs2_data_o = rs2_store;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, a negedge monitor compares.
module tb_register_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, rd_data;
  logic            rd_we;

  typedef struct {
    string           name;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .rd_addr_i  (rd_addr),
    .rd_data_i  (rd_data),
    .rd_we_i    (rd_we)
  );

  // Monitor: read outputs are valid mid-cycle; compare one queued entry per cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rs1_data !== e.e1) begin
        n_errors++;
        $display("FAIL %s rs1: got %h expected %h", e.name, rs1_data, e.e1);
      end
      n_checks++;
      if (rs2_data !== e.e2) begin
        n_errors++;
        $display("FAIL %s rs2: got %h expected %h", e.name, rs2_data, e.e2);
      end
    end
  end

  // Drive one cycle of inputs; optionally queue the expected read data for this cycle
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [XLEN-1:0] e1,
                      input logic [XLEN-1:0] e2, input string nm, input bit chk);
    exp_t e;
    rst      = r;
    rd_we    = we;
    rd_addr  = wa;
    rd_data  = wd;
    rs1_addr = a1;
    rs2_addr = a2;
    if (chk) begin
      e.name = nm;
      e.e1   = e1;
      e.e2   = e2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] same_cycle_exp;
`ifdef REGFILE_WRITE_BYPASS_EN
    same_cycle_exp = 32'h22;
`else
    same_cycle_exp = 32'h11;
`endif
    rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
    @(posedge clk);
    #1;

    // Reset state on every address, both ports
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, AW'(a), AW'(31 - a), 32'h0, 32'h0, "reset_sweep", 1'b1);
    end

    // Basic write to x5; neighbours untouched
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd4, 5'd6, 32'h0, 32'h0, "wr_x5_cycle", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "rd_x5", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 32'h0, 32'h0, "rd_x4_x6", 1'b1);

    // x0 protection, including no forwarding on x0
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, "wr_x0_cycle", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, "rd_x0", 1'b1);

    // Write enable low
    step(1'b0, 1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd7, 32'h0, 32'h0, "we0_cycle", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h0, 32'h0, "we0_x7", 1'b1);

    // Read during write on x3
    step(1'b0, 1'b1, 5'd3, 32'h11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "wr_x3_11", 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, same_cycle_exp, same_cycle_exp, "rdw_x3", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'h22, 32'h22, "after_rdw_x3", 1'b1);

    // Reset beats a coincident write; reset also blocks forwarding
    step(1'b0, 1'b1, 5'd9, 32'h55, 5'd5, 5'd3, 32'hDEADBEEF, 32'h22, "wr_x9_55", 1'b1);
    step(1'b1, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd5, 32'h55, 32'hDEADBEEF, "rst_wr_cycle", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h0, 32'h0, "after_rst_wr", 1'b1);

    // Fill x1..x31 with their index, checking the previous write each cycle
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, AW'(i), XLEN'(i), AW'(i - 1), 5'd0, XLEN'(i - 1), 32'h0, "fill", 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i), XLEN'(i), XLEN'(31 - i), "readback", 1'b1);
    end

    // Disabled write after fill leaves contents intact
    step(1'b0, 1'b0, 5'd12, 32'h0, 5'd12, 5'd12, 32'd12, 32'd12, "we0_x12", 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13, 32'd12, 32'd13, "after_we0_x12", 1'b1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
